// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one registered three-operand adder core
// between two requesters, with a valid/ready response channel.
module adder_share_ctrl #(
  parameter int W       = 3,
  parameter int SUM_W   = 6,
  parameter int ADD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [W-1:0]     req0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [W-1:0]     req1_c,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic [W-1:0]     add_c,
  input  logic [SUM_W-1:0] add_sum,
  input  logic             add_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [SUM_W-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ADD_LAT - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic [3:0]       r_cnt;
  logic [W-1:0]     r_add_a;
  logic [W-1:0]     r_add_b;
  logic [W-1:0]     r_add_c;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [SUM_W-1:0] r_rsp_sum;
  logic             r_rsp_carry;

  logic             w_grant_vld;
  logic             w_winner;
  logic             w_idle;
  logic [W-1:0]     w_op_a;
  logic [W-1:0]     w_op_b;
  logic [W-1:0]     w_op_c;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_winner    = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_vld = 1'b1;
      w_winner    = ~r_last_grant;
    end else if (req0_valid) begin
      w_grant_vld = 1'b1;
      w_winner    = 1'b0;
    end else if (req1_valid) begin
      w_grant_vld = 1'b1;
      w_winner    = 1'b1;
    end else begin
      w_grant_vld = 1'b0;
      w_winner    = 1'b0;
    end
  end

  assign w_idle     = (r_state == ST_IDLE);
  assign w_op_a     = w_winner ? req1_a : req0_a;
  assign w_op_b     = w_winner ? req1_b : req0_b;
  assign w_op_c     = w_winner ? req1_c : req0_c;
  assign req0_ready = w_idle && w_grant_vld && !w_winner;
  assign req1_ready = w_idle && w_grant_vld && w_winner;

  // Sequencer: grant, wait the core latency, hold the response until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
      r_add_a      <= {W{1'b0}};
      r_add_b      <= {W{1'b0}};
      r_add_c      <= {W{1'b0}};
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_sum    <= {SUM_W{1'b0}};
      r_rsp_carry  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_add_a      <= w_op_a;
            r_add_b      <= w_op_b;
            r_add_c      <= w_op_c;
            r_rsp_id     <= w_winner;
            r_last_grant <= w_winner;
            r_cnt        <= LAT_M1;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_sum   <= add_sum;
            r_rsp_carry <= add_carry;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_c     = r_add_c;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_carry = r_rsp_carry;
  assign busy      = !w_idle;

endmodule
